pipeline_stall_controller: RTL and testbench

Pipeline-control responder that consumes the load-use stall request from the hazard detection unit, the EX-stage branch/jump redirect, and the data-memory busy signal. It converts them into per-stage write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM. It enforces a fixed priority, stretches load-use stalls over a programmable number of cycles, and watches for hung memory accesses. It also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_stall_controller.sv | 117 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: combines load-use stalls, EX redirects and
// data-memory busy into per-stage enables/flushes, with perf counters and a hung-memory watchdog.
module pipeline_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             redirect_req,
  input  logic             mem_busy,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(MEM_TIMEOUT);
  localparam logic [2:0]  STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t      state;
  state_t      saved_state;
  state_t      eff_state;
  logic [2:0]  remaining;
  logic [15:0] busy_cnt;
  logic        stall_cycle;

  // Once mem_busy drops, MEM_WAIT behaves as the state it interrupted in that same cycle.
  always_comb begin
    eff_state   = (state == MEM_WAIT) ? saved_state : state;
    stall_cycle = (eff_state == LOAD_STALL) || ((eff_state == RUN) && stall_req);
  end

  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_write_en = 1'b1;
    if (!rst_n) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (mem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
    end else if (redirect_req) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall_cycle) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      saved_state <= RUN;
      remaining   <= '0;
      busy_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (mem_busy) begin
        state <= MEM_WAIT;
        if (state != MEM_WAIT) saved_state <= state;
      end else if (redirect_req) begin
        state     <= RUN;
        remaining <= '0;
        if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end else if (eff_state == LOAD_STALL) begin
        if (remaining <= 3'd1) begin
          state     <= RUN;
          remaining <= '0;
        end else begin
          state     <= LOAD_STALL;
          remaining <= remaining - 3'd1;
        end
      end else if (stall_req && (LOAD_STALL_CYCLES > 1)) begin
        state     <= LOAD_STALL;
        remaining <= STALL_RELOAD;
      end else begin
        state <= RUN;
      end

      if (!pc_write_en && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);

      if (!mem_busy) begin
        busy_cnt <= '0;
      end else if (busy_cnt != TO_LIMIT) begin
        busy_cnt <= busy_cnt + 16'd1;
        if ((busy_cnt + 16'd1) == TO_LIMIT) mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: two parameterisations share stimulus,
// each queued expectation names the instance it checks.
module tb_pipeline_stall_controller;

  localparam logic [4:0] NRM = 5'b11001; // {pc_we, if_id_we, if_id_fl, id_ex_fl, ex_mem_we}
  localparam logic [4:0] STL = 5'b00011;
  localparam logic [4:0] FRZ = 5'b00000;
  localparam logic [4:0] RDR = 5'b11111;
  localparam logic [4:0] RST = 5'b00110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_req = 1'b0;
  logic redirect_req = 1'b0;
  logic mem_busy = 1'b0;

  logic       a_pc, a_ifwe, a_iffl, a_idfl, a_exwe, a_to;
  logic [1:0] a_st;
  logic [3:0] a_sc, a_fc;
  logic       b_pc, b_ifwe, b_iffl, b_idfl, b_exwe, b_to;
  logic [1:0] b_st;
  logic [31:0] b_sc, b_fc;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(5), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .redirect_req(redirect_req),
    .mem_busy(mem_busy), .pc_write_en(a_pc), .if_id_write_en(a_ifwe),
    .if_id_flush(a_iffl), .id_ex_flush(a_idfl), .ex_mem_write_en(a_exwe),
    .mem_timeout(a_to), .ctrl_state(a_st), .stall_count(a_sc), .flush_count(a_fc)
  );

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(5), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .redirect_req(redirect_req),
    .mem_busy(mem_busy), .pc_write_en(b_pc), .if_id_write_en(b_ifwe),
    .if_id_flush(b_iffl), .id_ex_flush(b_idfl), .ex_mem_write_en(b_exwe),
    .mem_timeout(b_to), .ctrl_state(b_st), .stall_count(b_sc), .flush_count(b_fc)
  );

  typedef struct {
    int unsigned sel;
    int unsigned id;
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic        to;
    bit          chk_cnt;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cur_sel = 0;
  int unsigned step_id = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input int unsigned id,
                       input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [4:0]  ctrl;
      logic [1:0]  st;
      logic        to;
      int unsigned sc, fc;
      e = sb.pop_front();
      if (e.sel == 0) begin
        ctrl = {a_pc, a_ifwe, a_iffl, a_idfl, a_exwe};
        st = a_st; to = a_to; sc = 32'(a_sc); fc = 32'(a_fc);
      end else begin
        ctrl = {b_pc, b_ifwe, b_iffl, b_idfl, b_exwe};
        st = b_st; to = b_to; sc = b_sc; fc = b_fc;
      end
      check("ctrl", e.id, 32'(ctrl), 32'(e.ctrl));
      check("state", e.id, 32'(st), 32'(e.st));
      check("timeout", e.id, 32'(to), 32'(e.to));
      if (e.chk_cnt) begin
        check("stall_count", e.id, sc, e.sc);
        check("flush_count", e.id, fc, e.fc);
      end
    end
  end

  task automatic step(input bit rst, input bit busy, input bit redir, input bit stall,
                      input logic [4:0] ctrl, input logic [1:0] st, input bit to,
                      input bit chk_cnt, input int unsigned sc, input int unsigned fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    mem_busy     = busy;
    redirect_req = redir;
    stall_req    = stall;
    e.sel = cur_sel; e.id = step_id; e.ctrl = ctrl; e.st = st; e.to = to;
    e.chk_cnt = chk_cnt; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    step_id++;
  endtask

  task automatic rst_and_idle();
    step(0, 0, 0, 0, RST, 2'd0, 0, 1, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Instance A: LOAD_STALL_CYCLES=2, MEM_TIMEOUT=5, CNT_W=4
    cur_sel = 0;
    rst_and_idle();
    step(1, 0, 0, 1, STL, 2'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, STL, 2'd1, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 2, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 2, 0);

    rst_and_idle();
    step(1, 0, 1, 1, RDR, 2'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 0, 1);

    rst_and_idle();
    step(1, 1, 0, 0, FRZ, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, FRZ, 2'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 4, 0);
    step(1, 1, 0, 0, FRZ, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, FRZ, 2'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd2, 1, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 1, 1, 9, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 1, 0, 0, 0);

    rst_and_idle();
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, RDR, 2'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 0, 15);

    rst_and_idle();
    step(1, 0, 0, 1, STL, 2'd0, 0, 0, 0, 0);
    step(0, 0, 0, 0, RST, 2'd0, 0, 1, 0, 0);

    // Instance B: LOAD_STALL_CYCLES=3, MEM_TIMEOUT=5, CNT_W=32
    cur_sel = 1;
    rst_and_idle();
    step(1, 0, 0, 1, STL, 2'd0, 0, 0, 0, 0);
    step(1, 0, 1, 0, RDR, 2'd1, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 1, 1);

    rst_and_idle();
    step(1, 0, 0, 1, STL, 2'd0, 0, 0, 0, 0);
    step(1, 1, 0, 0, FRZ, 2'd1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, FRZ, 2'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, STL, 2'd2, 0, 0, 0, 0);
    step(1, 0, 0, 0, STL, 2'd1, 0, 0, 0, 0);
    step(1, 0, 0, 0, NRM, 2'd0, 0, 1, 7, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
